vga_timing_gen: RTL

Free-running VGA raster timing generator for 640x480@60 Hz. It sits directly upstream of the pixel-colour logic and drives that stage's `pixel_x`/`pixel_y` inputs. It produces sync and blanking signals, plus a copy of them delayed to match the colour pipeline's latency, so `hsync`/`vsync`/`blank` reach the DAC aligned with `pixel_r/g/b`.

---
 rtl/vga_timing_gen_pkg.sv | 49 ++++
 rtl/vga_timing_gen_sync_delay.sv | 40 ++++
 rtl/vga_timing_gen.sv | 104 ++++++++++
 3 files changed

// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - 640x480@60 raster constants, sync bundle type and region decode
//
// Holds every timing constant shared by the timing generator and the colour stage.
// Base constants follow the usual VESA naming; the *_BEG/*_END/*_LAST values are the
// same numbers pre-sized to the 10-bit counter width so comparisons stay width-clean.
package vga_timing_gen_pkg;

   localparam int H_VIS  = 640;
   localparam int H_FP   = 16;
   localparam int H_SYNC = 96;
   localparam int H_BP   = 48;
   localparam int H_TOT  = 800;

   localparam int V_VIS  = 480;
   localparam int V_FP   = 10;
   localparam int V_SYNC = 2;
   localparam int V_BP   = 33;
   localparam int V_TOT  = 525;

   localparam int CNT_W = 10;

   localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOT - 1);
   localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOT - 1);
   localparam logic [CNT_W-1:0] H_BLANK_BEG = CNT_W'(H_VIS);
   localparam logic [CNT_W-1:0] V_BLANK_BEG = CNT_W'(V_VIS);
   localparam logic [CNT_W-1:0] H_SYNC_BEG  = CNT_W'(H_VIS + H_FP);
   localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] V_SYNC_BEG  = CNT_W'(V_VIS + V_FP);
   localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_VIS + V_FP + V_SYNC - 1);

   // Bundle carried through the colour-latency delay line; hsync is the MSB.
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic blank;
   } sync_bits_t;

   // Region decode for one raster position; pol is the active sync level.
   function automatic sync_bits_t decode_sync(input logic [CNT_W-1:0] x,
                                              input logic [CNT_W-1:0] y,
                                              input logic             pol);
      sync_bits_t s;
      s.hsync = (x >= H_SYNC_BEG && x <= H_SYNC_END) ? pol : ~pol;
      s.vsync = (y >= V_SYNC_BEG && y <= V_SYNC_END) ? pol : ~pol;
      s.blank = (x >= H_BLANK_BEG) || (y >= V_BLANK_BEG);
      return s;
   endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// rtl/vga_timing_gen_sync_delay.sv - parameterised reset-filled shift register (sync_delay)
//
// Ports:
//   clk   in  1      system clock, rising edge
//   rst   in  1      synchronous active-high reset, loads RST_VAL into every stage
//   din   in  WIDTH  value entering the line
//   dout  out WIDTH  din from DEPTH clocks earlier (combinational copy when DEPTH=0)
module sync_delay #(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_pass;
         assign unused_pass = clk ^ rst;
         assign dout = din;
      end else begin : g_shift
         logic [WIDTH-1:0] stage [DEPTH];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else begin
               stage[0] <= din;
               for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
         end

         assign dout = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running 640x480@60 raster timing generator
//
// Ports:
//   clk          in  1   system clock, rising edge
//   rst          in  1   synchronous active-high reset
//   pix_en       out 1   one-clock pulse per pixel period (every PIX_DIV clocks)
//   pixel_x      out 10  horizontal position 0..799
//   pixel_y      out 10  vertical position 0..524
//   hsync/vsync  out 1   sync at active level SYNC_POL, aligned with pixel_x/pixel_y
//   blank        out 1   position outside the visible 640x480 area
//   frame_start  out 1   one-clock pulse after the (799,524)->(0,0) wrap
//   *_d          out 1   hsync/vsync/blank delayed LAT clocks for the colour pipeline
module vga_timing_gen
   import vga_timing_gen_pkg::*;
#(
   parameter int PIX_DIV  = 4,
   parameter int LAT      = 2,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   output logic             pix_en,
   output logic [CNT_W-1:0] pixel_x,
   output logic [CNT_W-1:0] pixel_y,
   output logic             hsync,
   output logic             vsync,
   output logic             blank,
   output logic             frame_start,
   output logic             hsync_d,
   output logic             vsync_d,
   output logic             blank_d
);

   localparam int               DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

   // Delay stages start as "deasserted sync, blanked" so the DAC sees nothing
   // until real raster values have propagated through.
   localparam sync_bits_t SYNC_FILL = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, blank: 1'b1};

   logic [DIV_W-1:0] div;
   logic [CNT_W-1:0] x_nxt;
   logic [CNT_W-1:0] y_nxt;
   sync_bits_t       sync_nxt;
   sync_bits_t       sync_now;
   sync_bits_t       sync_dly;

   // Position the counters take on the coming edge; sync/blank are decoded
   // from it so they register on the same edge as the counters.
   always_comb begin
      x_nxt = pixel_x;
      y_nxt = pixel_y;
      if (pix_en) begin
         if (pixel_x == H_LAST) begin
            x_nxt = '0;
            y_nxt = (pixel_y == V_LAST) ? '0 : pixel_y + CNT_W'(1);
         end else begin
            x_nxt = pixel_x + CNT_W'(1);
         end
      end
   end

   assign sync_nxt = decode_sync(x_nxt, y_nxt, SYNC_POL);

   always_ff @(posedge clk) begin
      if (rst) begin
         div         <= '0;
         pix_en      <= 1'b0;
         pixel_x     <= '0;
         pixel_y     <= '0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         blank       <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         div         <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
         pix_en      <= (div == DIV_LAST);
         pixel_x     <= x_nxt;
         pixel_y     <= y_nxt;
         hsync       <= sync_nxt.hsync;
         vsync       <= sync_nxt.vsync;
         blank       <= sync_nxt.blank;
         frame_start <= pix_en && (pixel_x == H_LAST) && (pixel_y == V_LAST);
      end
   end

   assign sync_now = '{hsync: hsync, vsync: vsync, blank: blank};

   sync_delay #(
      .WIDTH   (3),
      .DEPTH   (LAT),
      .RST_VAL (SYNC_FILL)
   ) u_sync_delay (
      .clk  (clk),
      .rst  (rst),
      .din  (sync_now),
      .dout (sync_dly)
   );

   assign hsync_d = sync_dly.hsync;
   assign vsync_d = sync_dly.vsync;
   assign blank_d = sync_dly.blank;

endmodule
